// File: rtl/ddr_tx_if.sv
// Bundle between the DDR controller/data sources and the DDR serial transmitter.
// The master side drives commands and operands; the slave side is the transmitter.
interface ddr_tx_if;
   logic       i_sclgen_scl_pos_edge;
   logic       i_sclgen_scl_neg_edge;
   logic       i_ddrccc_tx_en;
   logic [3:0] i_ddrccc_tx_mode;
   logic [7:0] i_regfcrc_tx_data_in;
   logic [4:0] i_crc_value;
   logic       o_sdahnd_tx_sda;
   logic       o_ddrccc_tx_mode_done;
   logic       o_crc_en;
   logic [7:0] o_crc_data_out;

   modport master (
      output i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_ddrccc_tx_en,
             i_ddrccc_tx_mode, i_regfcrc_tx_data_in, i_crc_value,
      input  o_sdahnd_tx_sda, o_ddrccc_tx_mode_done, o_crc_en, o_crc_data_out
   );

   modport slave (
      input  i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge, i_ddrccc_tx_en,
             i_ddrccc_tx_mode, i_regfcrc_tx_data_in, i_crc_value,
      output o_sdahnd_tx_sda, o_ddrccc_tx_mode_done, o_crc_en, o_crc_data_out
   );
endinterface

// File: rtl/ddr_tx.sv
// HDR-DDR serial transmitter: shifts preamble, data, parity, CRC token and CRC
// value onto SDA, one bit per SCL edge, with a done pulse per completed field.
module ddr_tx (
   input  logic     i_sys_clk,
   input  logic     i_sys_rst,
   ddr_tx_if.slave  tx_if
);

   typedef enum logic [3:0] {
      MODE_PRE0   = 4'b0000,
      MODE_PRE1   = 4'b0001,
      MODE_BYTE   = 4'b0010,
      MODE_PARITY = 4'b0011,
      MODE_TOKEN  = 4'b0100,
      MODE_CRC    = 4'b0101,
      MODE_IDLE   = 4'b1111
   } mode_e;

   logic [3:0]  r_mode_q;
   logic        r_en_q;
   logic        r_done;
   logic [3:0]  r_cnt;
   logic [7:0]  r_shift;
   logic        r_sda;
   logic [15:0] r_word;
   logic        r_byte_idx;
   logic        r_crc_en;
   logic [7:0]  r_crc_data;

   mode_e       w_mode;
   logic        w_edge;
   logic        w_start;
   logic [15:0] w_pword;
   logic        w_pa1;
   logic        w_pa0;
   logic [7:0]  w_operand;
   logic [3:0]  w_len;
   logic [3:0]  w_cnt;
   logic [7:0]  w_shift;
   logic [7:0]  w_rot;
   logic        w_last;
   logic        w_byte_done;

   always_comb begin
      case (tx_if.i_ddrccc_tx_mode)
         4'b0000: w_mode = MODE_PRE0;
         4'b0001: w_mode = MODE_PRE1;
         4'b0010: w_mode = MODE_BYTE;
         4'b0011: w_mode = MODE_PARITY;
         4'b0100: w_mode = MODE_TOKEN;
         4'b0101: w_mode = MODE_CRC;
         default: w_mode = MODE_IDLE;
      endcase
   end

   always_comb begin
      w_edge  = tx_if.i_sclgen_scl_pos_edge | tx_if.i_sclgen_scl_neg_edge;
      w_start = tx_if.i_ddrccc_tx_en &&
                (!r_en_q || r_done || (tx_if.i_ddrccc_tx_mode != r_mode_q));

      // A lone first byte leaves a stale low byte in the word; parity sees zeros.
      w_pword = {r_word[15:8], r_byte_idx ? 8'h00 : r_word[7:0]};
      w_pa1   = ^(w_pword & 16'hAAAA);
      w_pa0   = ~^(w_pword & 16'h5555);

      w_operand = 8'hFF;
      w_len     = 4'd0;
      case (w_mode)
         MODE_PRE0:   begin w_operand = 8'h00;                   w_len = 4'd1; end
         MODE_PRE1:   begin w_operand = 8'h80;                   w_len = 4'd1; end
         MODE_BYTE:   begin w_operand = tx_if.i_regfcrc_tx_data_in; w_len = 4'd8; end
         MODE_PARITY: begin w_operand = {w_pa1, w_pa0, 6'b0};    w_len = 4'd2; end
         MODE_TOKEN:  begin w_operand = 8'hC0;                   w_len = 4'd4; end
         MODE_CRC:    begin w_operand = {tx_if.i_crc_value, 3'b0}; w_len = 4'd5; end
         default:     begin w_operand = 8'hFF;                   w_len = 4'd0; end
      endcase

      // A start and an edge may land in the same cycle: the edge then uses the fresh operand.
      w_cnt       = w_start ? 4'd0 : r_cnt;
      w_shift     = w_start ? w_operand : r_shift;
      w_rot       = {w_shift[6:0], w_shift[7]};
      w_last      = (w_len != 4'd0) && (w_cnt == w_len - 4'd1);
      w_byte_done = (w_mode == MODE_BYTE) && (w_cnt == 4'd7);
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_mode_q   <= 4'b1111;
         r_en_q     <= 1'b0;
         r_done     <= 1'b0;
         r_cnt      <= 4'd0;
         r_shift    <= 8'hFF;
         r_sda      <= 1'b1;
         r_word     <= 16'h0000;
         r_byte_idx <= 1'b0;
         r_crc_en   <= 1'b0;
         r_crc_data <= 8'h00;
      end else begin
         r_mode_q <= tx_if.i_ddrccc_tx_mode;
         r_en_q   <= tx_if.i_ddrccc_tx_en;
         r_done   <= 1'b0;
         r_crc_en <= 1'b0;
         if (!tx_if.i_ddrccc_tx_en) begin
            r_cnt      <= 4'd0;
            r_byte_idx <= 1'b0;
         end else begin
            r_cnt   <= w_cnt;
            r_shift <= w_shift;
            if (w_edge) begin
               r_sda <= w_shift[7];
               // Rotate rather than shift so the byte is whole again after its 8th bit.
               r_shift <= w_rot;
               if (w_last) begin
                  r_cnt  <= 4'd0;
                  r_done <= 1'b1;
               end else if (w_len != 4'd0) begin
                  r_cnt <= w_cnt + 4'd1;
               end
               if (w_byte_done) begin
                  r_crc_en   <= 1'b1;
                  r_crc_data <= w_rot;
                  r_byte_idx <= ~r_byte_idx;
                  if (r_byte_idx) r_word[7:0]  <= w_rot;
                  else            r_word[15:8] <= w_rot;
               end
               if ((w_mode == MODE_PARITY) && w_last) r_byte_idx <= 1'b0;
            end
         end
      end
   end

   assign tx_if.o_sdahnd_tx_sda       = r_sda;
   assign tx_if.o_ddrccc_tx_mode_done = r_done;
   assign tx_if.o_crc_en              = r_crc_en;
   assign tx_if.o_crc_data_out        = r_crc_data;

endmodule

// File: tb/tb_ddr_tx.sv
// Directed bench for ddr_tx: a vector table of per-edge expectations plus
// hand sequences for abort, reset, disable and back-to-back edge cases.
module tb_ddr_tx;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ddr_tx_if u_if ();

   ddr_tx dut (
      .i_sys_clk (clk),
      .i_sys_rst (rst),
      .tx_if     (u_if)
   );

   typedef struct {
      logic [3:0] mode;
      logic [7:0] data;
      logic [4:0] crc;
      logic       pos;
      logic       neg;
      logic       sda;
      logic       done;
      logic       cen;
      logic [7:0] cdat;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One field: n edges, expected bits MSB-first in bits, both-edge pulses per mask.
   task automatic add_field(input logic [3:0] m, input logic [7:0] d, input logic [4:0] c,
                            input int n, input logic [7:0] bits, input logic [7:0] both,
                            input logic has_done);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.mode = m; v.data = d; v.crc = c;
         v.pos  = 1'b1;
         v.neg  = both[7-k];
         v.sda  = bits[7-k];
         v.done = has_done && (k == n-1);
         v.cen  = (m == 4'b0010) && (k == n-1);
         v.cdat = d;
         vq.push_back(v);
      end
   endtask

   task automatic set_in(input logic [3:0] m, input logic [7:0] d, input logic [4:0] c);
      u_if.i_ddrccc_tx_mode     = m;
      u_if.i_regfcrc_tx_data_in = d;
      u_if.i_crc_value          = c;
   endtask

   task automatic pulse(input logic p, input logic n);
      @(negedge clk);
      u_if.i_sclgen_scl_pos_edge = p;
      u_if.i_sclgen_scl_neg_edge = n;
      @(negedge clk);
      u_if.i_sclgen_scl_pos_edge = 1'b0;
      u_if.i_sclgen_scl_neg_edge = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic s, input logic d, input logic ce);
      chk({name, ".sda"},  {7'b0, u_if.o_sdahnd_tx_sda},       {7'b0, s});
      chk({name, ".done"}, {7'b0, u_if.o_ddrccc_tx_mode_done}, {7'b0, d});
      chk({name, ".cen"},  {7'b0, u_if.o_crc_en},              {7'b0, ce});
   endtask

   initial begin
      logic [7:0] b5a;
      logic [7:0] bcrc;
      rst = 1'b1;
      u_if.i_sclgen_scl_pos_edge = 1'b0;
      u_if.i_sclgen_scl_neg_edge = 1'b0;
      u_if.i_ddrccc_tx_en        = 1'b0;
      set_in(4'hF, 8'h00, 5'h00);

      add_field(4'h1, 8'h00, 5'h00, 1, 8'h80, 8'h00, 1'b1);
      add_field(4'h0, 8'h00, 5'h00, 1, 8'h00, 8'h00, 1'b1);
      add_field(4'h9, 8'h00, 5'h00, 1, 8'h80, 8'h00, 1'b0);
      add_field(4'h2, 8'hA5, 5'h00, 8, 8'hA5, 8'h00, 1'b1);
      add_field(4'h2, 8'h3C, 5'h00, 8, 8'h3C, 8'h00, 1'b1);
      add_field(4'h3, 8'h00, 5'h00, 2, 8'h40, 8'h00, 1'b1);
      add_field(4'h4, 8'h00, 5'h00, 4, 8'hC0, 8'h00, 1'b1);
      add_field(4'h5, 8'h00, 5'b10110, 5, 8'hB0, 8'h00, 1'b1);
      add_field(4'hF, 8'h00, 5'h00, 1, 8'h80, 8'h00, 1'b0);
      add_field(4'h2, 8'hFF, 5'h00, 8, 8'hFF, 8'h24, 1'b1);
      add_field(4'h2, 8'h03, 5'h00, 8, 8'h03, 8'h00, 1'b1);
      add_field(4'h3, 8'h00, 5'h00, 2, 8'h80, 8'h00, 1'b1);
      add_field(4'h2, 8'h80, 5'h00, 8, 8'h80, 8'h00, 1'b1);
      add_field(4'h3, 8'h00, 5'h00, 2, 8'hC0, 8'h00, 1'b1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.sda",  {7'b0, u_if.o_sdahnd_tx_sda},       8'h01);
      chk("reset.done", {7'b0, u_if.o_ddrccc_tx_mode_done}, 8'h00);
      chk("reset.cen",  {7'b0, u_if.o_crc_en},              8'h00);
      chk("reset.cdat", u_if.o_crc_data_out,                8'h00);
      rst = 1'b0;
      u_if.i_ddrccc_tx_en = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         set_in(vq[i].mode, vq[i].data, vq[i].crc);
         pulse(vq[i].pos, vq[i].neg);
         chk_out($sformatf("vec%0d", i), vq[i].sda, vq[i].done, vq[i].cen);
         if (vq[i].cen) chk($sformatf("vec%0d.cdat", i), u_if.o_crc_data_out, vq[i].cdat);
      end

      // Byte abandoned after 3 edges by a switch to PREAMBLE_ZERO.
      set_in(4'h2, 8'hC3, 5'h00);
      pulse(1'b1, 1'b0); chk_out("sw.b0", 1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0); chk_out("sw.b1", 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1); chk_out("sw.b2", 1'b0, 1'b0, 1'b0);
      set_in(4'h0, 8'hC3, 5'h00);
      pulse(1'b1, 1'b0); chk_out("sw.pre0", 1'b0, 1'b1, 1'b0);

      // Disable after 5 edges of 5A; SDA holds, re-enable restarts at bit 7.
      b5a = 8'h5A;
      set_in(4'h2, 8'h5A, 5'h00);
      for (int k = 0; k < 5; k++) begin
         pulse(1'b1, 1'b0);
         chk_out($sformatf("dis.a%0d", k), b5a[7-k], 1'b0, 1'b0);
      end
      u_if.i_ddrccc_tx_en = 1'b0;
      pulse(1'b1, 1'b0); chk_out("dis.hold", 1'b1, 1'b0, 1'b0);
      u_if.i_ddrccc_tx_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         pulse(1'b1, 1'b0);
         chk_out($sformatf("dis.r%0d", k), b5a[7-k], k == 7, k == 7);
      end
      chk("dis.cdat", u_if.o_crc_data_out, 8'h5A);

      // Synchronous reset after 5 edges of 5A aborts the byte.
      set_in(4'h2, 8'h5A, 5'h00);
      for (int k = 0; k < 5; k++) begin
         pulse(1'b1, 1'b0);
         chk_out($sformatf("rst.a%0d", k), b5a[7-k], 1'b0, 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_out("rst.after", 1'b1, 1'b0, 1'b0);
      set_in(4'h2, 8'hFF, 5'h00);
      pulse(1'b1, 1'b0); chk_out("rst.restart", 1'b1, 1'b0, 1'b0);

      // Back-to-back edges every cycle; next field presented in the done cycle.
      set_in(4'h4, 8'h00, 5'h00);
      @(negedge clk);
      u_if.i_sclgen_scl_pos_edge = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk_out($sformatf("b2b.tok%0d", k), (k < 2), k == 3, 1'b0);
      end
      set_in(4'h5, 8'h00, 5'b10110);
      bcrc = 8'hB0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 4) u_if.i_sclgen_scl_pos_edge = 1'b0;
         chk_out($sformatf("b2b.crc%0d", k), bcrc[7-k], k == 4, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
